// File: rtl/action_select_pkg.sv
// Shared widths, LFSR seed, action/state encodings and the LFSR step function
// used by the epsilon-greedy action selector.
package action_select_pkg;

  localparam int STATES_W  = 5;
  localparam int ACTIONS_W = 2;
  localparam int Q_W       = 16;
  localparam int EPS_W     = 8;

  localparam logic [7:0] LFSR_SEED = 8'hA5;

  typedef enum logic [1:0] {
    ACT_UP    = 2'd0,
    ACT_DOWN  = 2'd1,
    ACT_RIGHT = 2'd2,
    ACT_LEFT  = 2'd3
  } action_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2,
    S_OUT   = 2'd3
  } state_e;

  // Fibonacci step for x^8+x^6+x^5+x^4+1; a nonzero seed never reaches zero.
  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

endpackage

// File: rtl/action_select_lfsr8.sv
// Free-running 8-bit Fibonacci LFSR supplying the exploration random value.
module lfsr8
  import action_select_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  output logic [7:0] out
);

  logic [7:0] lfsr_q;
  logic [7:0] lfsr_d;

  always_comb lfsr_d = lfsr_next(lfsr_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= LFSR_SEED;
    else        lfsr_q <= lfsr_d;
  end

  assign out = lfsr_q;

endmodule

// File: rtl/action_select.sv
// Epsilon-greedy action selector: reads the four Q-values of a state, tracks
// the signed argmax and either returns it or a random action.
module action_select
  import action_select_pkg::*;
#(
  parameter int STATES_WIDTH  = STATES_W,
  parameter int ACTIONS_WIDTH = ACTIONS_W,
  parameter int Q_WIDTH       = Q_W,
  parameter int EPS_WIDTH     = EPS_W
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   start,
  input  logic [STATES_WIDTH-1:0]                st,
  input  logic [EPS_WIDTH-1:0]                   epsilon,
  output logic                                   q_rd_en,
  output logic [STATES_WIDTH+ACTIONS_WIDTH-1:0]  q_rd_addr,
  input  logic [Q_WIDTH-1:0]                     q_rd_data,
  output logic [ACTIONS_WIDTH-1:0]               at,
  output logic                                   valid_out,
  output logic                                   explore,
  output logic                                   busy
);

  state_e                                state_q, state_d;
  logic [ACTIONS_WIDTH-1:0]              cnt_q, cnt_d, cnt_nxt;
  logic [STATES_WIDTH-1:0]               st_l_q, st_l_d;
  logic [EPS_WIDTH-1:0]                  eps_l_q, eps_l_d;
  logic [7:0]                            rnd_q, rnd_d, lfsr_out;
  logic                                  q_rd_en_q, q_rd_en_d;
  logic [STATES_WIDTH+ACTIONS_WIDTH-1:0] q_rd_addr_q, q_rd_addr_d;
  logic                                  rd_vld_q, rd_vld_d;
  logic [ACTIONS_WIDTH-1:0]              rd_idx_q, rd_idx_d;
  logic signed [Q_WIDTH-1:0]             max_q, max_d, cand_max;
  logic [ACTIONS_WIDTH-1:0]              max_idx_q, max_idx_d, cand_idx;
  logic [ACTIONS_WIDTH-1:0]              at_q, at_d;
  logic                                  explore_q, explore_d, explore_now;
  logic                                  valid_out_q, valid_out_d;
  logic                                  take;

  lfsr8 u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .out   (lfsr_out)
  );

  always_comb begin
    // Incoming read data competes with the running max; index 0 always loads.
    take     = rd_vld_q && ((rd_idx_q == '0) || ($signed(q_rd_data) > max_q));
    cand_max = take ? $signed(q_rd_data) : max_q;
    cand_idx = take ? rd_idx_q : max_idx_q;
    cnt_nxt  = cnt_q + ACTIONS_WIDTH'(1);
    explore_now = 32'(rnd_q) < 32'(eps_l_q);

    state_d     = state_q;
    cnt_d       = cnt_q;
    st_l_d      = st_l_q;
    eps_l_d     = eps_l_q;
    rnd_d       = rnd_q;
    q_rd_en_d   = 1'b0;
    q_rd_addr_d = q_rd_addr_q;
    rd_vld_d    = q_rd_en_q;
    rd_idx_d    = cnt_q;
    max_d       = rd_vld_q ? cand_max : max_q;
    max_idx_d   = rd_vld_q ? cand_idx : max_idx_q;
    at_d        = at_q;
    explore_d   = explore_q;
    valid_out_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          st_l_d      = st;
          eps_l_d     = epsilon;
          rnd_d       = lfsr_out;
          cnt_d       = '0;
          q_rd_en_d   = 1'b1;
          q_rd_addr_d = {st, {ACTIONS_WIDTH{1'b0}}};
          state_d     = S_READ;
        end
      end
      S_READ: begin
        if (cnt_q == '1) begin
          state_d = S_DRAIN;
        end else begin
          cnt_d       = cnt_nxt;
          q_rd_en_d   = 1'b1;
          q_rd_addr_d = {st_l_q, cnt_nxt};
        end
      end
      S_DRAIN: begin
        valid_out_d = 1'b1;
        explore_d   = explore_now;
        at_d        = explore_now ? rnd_q[ACTIONS_WIDTH-1:0] : cand_idx;
        state_d     = S_OUT;
      end
      S_OUT: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      st_l_q      <= '0;
      eps_l_q     <= '0;
      rnd_q       <= '0;
      q_rd_en_q   <= 1'b0;
      q_rd_addr_q <= '0;
      rd_vld_q    <= 1'b0;
      rd_idx_q    <= '0;
      max_q       <= '0;
      max_idx_q   <= '0;
      at_q        <= '0;
      explore_q   <= 1'b0;
      valid_out_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      st_l_q      <= st_l_d;
      eps_l_q     <= eps_l_d;
      rnd_q       <= rnd_d;
      q_rd_en_q   <= q_rd_en_d;
      q_rd_addr_q <= q_rd_addr_d;
      rd_vld_q    <= rd_vld_d;
      rd_idx_q    <= rd_idx_d;
      max_q       <= max_d;
      max_idx_q   <= max_idx_d;
      at_q        <= at_d;
      explore_q   <= explore_d;
      valid_out_q <= valid_out_d;
    end
  end

  assign q_rd_en   = q_rd_en_q;
  assign q_rd_addr = q_rd_addr_q;
  assign at        = at_q;
  assign explore   = explore_q;
  assign valid_out = valid_out_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_action_select.sv
// Scoreboard bench for action_select: a reference model predicts reads and
// decisions at start acceptance; a negedge monitor checks what the DUT presents.
module tb_action_select;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [4:0]  st = '0;
  logic [7:0]  epsilon = '0;
  logic        q_rd_en;
  logic [6:0]  q_rd_addr;
  logic [15:0] q_rd_data = '0;
  logic [1:0]  at;
  logic        valid_out;
  logic        explore;
  logic        busy;

  action_select dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .st        (st),
    .epsilon   (epsilon),
    .q_rd_en   (q_rd_en),
    .q_rd_addr (q_rd_addr),
    .q_rd_data (q_rd_data),
    .at        (at),
    .valid_out (valid_out),
    .explore   (explore),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] at;
    logic       explore;
    int         due;
  } exp_t;

  typedef struct {
    logic [6:0] addr;
    int         due;
  } rd_t;

  exp_t exp_q[$];
  rd_t  rd_q[$];

  logic signed [15:0] qmem [0:127];
  logic [7:0] m_lfsr;
  int         m_busy;
  int         cyc = 0;
  int         n_vec = 0;
  int         n_bad = 0;
  logic [1:0] last_at = '0;
  logic       last_exp = 1'b0;

  task automatic check(input string name, input int act, input int req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Greedy choice: first index holding the largest signed value.
  function automatic logic [1:0] greedy(input logic [4:0] s);
    int best;
    int bi;
    best = int'(qmem[{s, 2'd0}]);
    bi = 0;
    for (int a = 1; a < 4; a++)
      if (int'(qmem[{s, 2'(a)}]) > best) begin
        best = int'(qmem[{s, 2'(a)}]);
        bi = a;
      end
    return 2'(bi);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk)
    q_rd_data <= q_rd_en ? qmem[q_rd_addr] : 16'($urandom);

  // Reference model: LFSR sequence, busy window, and prediction at acceptance.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_lfsr <= 8'hA5;
      m_busy <= 0;
    end else begin
      m_lfsr <= {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
      if (m_busy == 0 && start) begin
        exp_t e;
        e.explore = (m_lfsr < epsilon);
        e.at      = e.explore ? m_lfsr[1:0] : greedy(st);
        e.due     = cyc + 6;
        exp_q.push_back(e);
        for (int a = 0; a < 4; a++) begin
          rd_t r;
          r.addr = {st, 2'(a)};
          r.due  = cyc + 1 + a;
          rd_q.push_back(r);
        end
        m_busy <= 6;
      end else if (m_busy != 0) begin
        m_busy <= m_busy - 1;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("busy", int'(busy), int'(m_busy != 0));
      if (q_rd_en) begin
        if (rd_q.size() == 0) check("rd_unexpected", 1, 0);
        else begin
          rd_t r;
          r = rd_q.pop_front();
          check("rd_addr", int'(q_rd_addr), int'(r.addr));
          check("rd_cycle", cyc, r.due);
        end
      end
      if (valid_out) begin
        if (exp_q.size() == 0) check("valid_unexpected", 1, 0);
        else begin
          exp_t e;
          e = exp_q.pop_front();
          check("at", int'(at), int'(e.at));
          check("explore", int'(explore), int'(e.explore));
          check("latency", cyc, e.due);
          last_at  = e.at;
          last_exp = e.explore;
        end
      end else begin
        check("at_hold", int'(at), int'(last_at));
        check("explore_hold", int'(explore), int'(last_exp));
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while (m_busy != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (m_busy != 0) check("idle_timeout", 1, 0);
  endtask

  task automatic issue(input logic [4:0] s, input logic [7:0] eps,
                       input int q0, input int q1, input int q2, input int q3,
                       input int noise);
    wait_idle();
    qmem[{s, 2'd0}] = 16'(q0);
    qmem[{s, 2'd1}] = 16'(q1);
    qmem[{s, 2'd2}] = 16'(q2);
    qmem[{s, 2'd3}] = 16'(q3);
    st = s;
    epsilon = eps;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (noise != 0) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      st = 5'($urandom_range(0, 24));
      epsilon = 8'($urandom);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_q_rd_en", int'(q_rd_en), 0);
    check("rst_q_rd_addr", int'(q_rd_addr), 0);
    check("rst_at", int'(at), 0);
    check("rst_valid_out", int'(valid_out), 0);
    check("rst_explore", int'(explore), 0);
    check("rst_busy", int'(busy), 0);
    exp_q.delete();
    rd_q.delete();
    last_at = '0;
    last_exp = 1'b0;
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 128; i++) qmem[i] = 16'($urandom);
    do_reset();

    issue(5'd7, 8'd0, 10, -3, 25, 4, 0);
    issue(5'd3, 8'd0, 5, 5, -1, 5, 0);
    issue(5'd3, 8'd0, -8, -2, -9, -2, 0);
    issue(5'd24, 8'd0, -32768, 32767, 0, 32767, 0);
    issue(5'd0, 8'd255, 1, 2, 3, 4, 0);
    issue(5'd12, 8'd255, -1, -1, -1, -1, 0);
    issue(5'd9, 8'd0, 100, 200, 300, 400, 1);

    // Abort in the middle of the reads, then a fresh request.
    wait_idle();
    st = 5'd5; epsilon = 8'd0;
    qmem[{5'd5, 2'd2}] = 16'sd900;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    do_reset();
    issue(5'd5, 8'd0, 1, 2, 900, 3, 0);

    for (int t = 0; t < 150; t++) begin
      int sel;
      int lo;
      int hi;
      logic [7:0] eps;
      sel = $urandom_range(0, 3);
      eps = (sel == 0) ? 8'd0 : (sel == 1) ? 8'd255 : 8'($urandom);
      lo = ($urandom_range(0, 1) == 0) ? -2 : -32768;
      hi = (lo == -2) ? 2 : 32767;
      issue(5'($urandom_range(0, 24)), eps,
            $urandom_range(0, hi - lo) + lo, $urandom_range(0, hi - lo) + lo,
            $urandom_range(0, hi - lo) + lo, $urandom_range(0, hi - lo) + lo,
            int'($urandom_range(0, 3) == 0));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    wait_idle();
    repeat (3) @(negedge clk);
    check("pending_results", exp_q.size(), 0);
    check("pending_reads", rd_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/action_select.md
ACTION_SELECT -- requirements
Module: action_select

Interface
REQ-001 SHALL have parameter STATES_WIDTH, default 5, state index width for the 25-cell grid.
REQ-002 SHALL have parameter ACTIONS_WIDTH, default 2, action code width (0 Up, 1 Down, 2 Right, 3 Left).
REQ-003 SHALL have parameter Q_WIDTH, default 16, signed two's-complement Q-value width.
REQ-004 SHALL have parameter EPS_WIDTH, default 8, exploration threshold width.
REQ-005 SHALL have port clk  input  1  sole clock, rising edge.
REQ-006 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port start  input  1  request action for st; sampled only in IDLE.
REQ-008 SHALL have port st  input  STATES_WIDTH  current state, captured on accepted start.
REQ-009 SHALL have port epsilon  input  EPS_WIDTH  exploration threshold, captured on accepted start.
REQ-010 SHALL have port q_rd_en  output  1  Q-table read strobe.
REQ-011 SHALL have port q_rd_addr  output  STATES_WIDTH+ACTIONS_WIDTH  read address {st, action}.
REQ-012 SHALL have port q_rd_data  input  Q_WIDTH  Q-table data, valid exactly 1 cycle after q_rd_en.
REQ-013 SHALL have port at  output  ACTIONS_WIDTH  selected action; drives next_state at.
REQ-014 SHALL have port valid_out  output  1  one-cycle pulse, at and explore valid; drives next_state valid_in.
REQ-015 SHALL have port explore  output  1  1 = random action, 0 = greedy action.
REQ-016 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-017 SHALL implement FSM IDLE -> READ -> DRAIN -> OUT -> IDLE.
REQ-018 IDLE: start=1 latches st, epsilon, LFSR value rnd; next READ, action counter cnt=0.
REQ-019 READ: q_rd_en=1, q_rd_addr={st_l,cnt}, cnt increments; after cnt=3 issued, go DRAIN.
REQ-020 Each returned q_rd_data SHALL be compared signed against running max; first data loads max unconditionally.
REQ-021 Replacement only on strictly greater value; ties keep lowest action index.
REQ-022 DRAIN: captures data for action 3, one cycle; next OUT.
REQ-023 OUT: valid_out=1 for exactly one cycle with at/explore registered; next IDLE.
REQ-024 valid_out SHALL assert 5 cycles after the cycle where start is sampled high; at/explore hold until next valid_out.
REQ-025 explore=1 iff rnd < epsilon (unsigned); then at=rnd[1:0], else at=greedy argmax.
REQ-026 epsilon=0 SHALL never explore; epsilon=255 explores unless rnd=255.
REQ-027 LFSR: 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1, advances every clock regardless of state, never zero.
REQ-028 start while busy SHALL be ignored, no queuing.
REQ-029 q_rd_en SHALL be 0 outside READ; q_rd_addr holds last value.

Reset
REQ-030 rst_n low SHALL immediately force IDLE, cnt=0, q_rd_en=0, q_rd_addr=0, at=0, valid_out=0, explore=0, busy=0, max=0.
REQ-031 LFSR SHALL reset to 8'hA5.
REQ-032 Reset mid-operation SHALL abort with no valid_out; first start after release behaves as fresh.

Structure
REQ-033 STATES_WIDTH, ACTIONS_WIDTH, Q_WIDTH, EPS_WIDTH, LFSR seed and action encodings SHALL live in shared params.v.
REQ-034 LFSR SHALL be sub-module lfsr8 (clk, rst_n, out[7:0]).

Verification
REQ-035 st=7, Q={10,-3,25,4}, epsilon=0 -> addresses 28,29,30,31 on consecutive cycles; at=2, explore=0, valid_out 5 cycles after start.
REQ-036 st=3, Q={5,5,-1,5}, epsilon=0 -> at=0 (tie to lowest index); Q={-8,-2,-9,-2} -> at=1.
REQ-037 st=24, epsilon=0 -> addresses 96..99, no wrap; valid_out single cycle.
REQ-038 epsilon=255, start sampled when model LFSR (seed A5) value r<255 -> explore=1, at=r[1:0]; matches model.
REQ-039 start pulsed during READ ignored (one valid_out only); rst_n low in READ -> all outputs 0 same cycle, no valid_out, next start yields correct result.
